// File: rtl/uart_alu_host.sv
// Host-side initiator for the UART ALU link: sends A, B and opcode as three
// UART bytes, then waits for the one-byte result or declares a timeout.
module uart_alu_host #(
  parameter int OP_W        = 6,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int TO_BITS     = 21
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [7:0]      cmd_a,
  input  logic [7:0]      cmd_b,
  input  logic [OP_W-1:0] cmd_op,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  input  logic            tx_done_tick,
  input  logic            rx_done_tick,
  input  logic [7:0]      rx_data,
  output logic            resp_valid,
  output logic [7:0]      resp_data,
  output logic            resp_timeout,
  output logic            busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_WAIT_TX = 2'd2;
  localparam logic [1:0] S_WAIT_RX = 2'd3;

  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYC - 1);

  logic [1:0]         state;
  logic [1:0]         idx;
  logic [7:0]         a_q;
  logic [7:0]         b_q;
  logic [OP_W-1:0]    op_q;
  logic [TO_BITS-1:0] to_cnt;
  logic [7:0]         cur_byte;

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    cur_byte = 8'h00;
    case (idx)
      2'd0:    cur_byte = a_q;
      2'd1:    cur_byte = b_q;
      default: cur_byte = 8'(op_q);
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= 2'd0;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      op_q         <= '0;
      to_cnt       <= '0;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      resp_valid   <= 1'b0;
      resp_data    <= 8'h00;
      resp_timeout <= 1'b0;
    end else begin
      // Pulses default low so each is exactly one cycle wide.
      tx_start   <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            a_q   <= cmd_a;
            b_q   <= cmd_b;
            op_q  <= cmd_op;
            idx   <= 2'd0;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          tx_start <= 1'b1;
          tx_data  <= cur_byte;
          state    <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (tx_done_tick) begin
            if (idx == 2'd2) begin
              to_cnt <= '0;
              state  <= S_WAIT_RX;
            end else begin
              idx   <= idx + 2'd1;
              state <= S_SEND;
            end
          end
        end
        default: begin
          to_cnt <= to_cnt + 1'b1;
          // A byte arriving on the expiry cycle still counts as a real reply.
          if (rx_done_tick) begin
            resp_data    <= rx_data;
            resp_timeout <= 1'b0;
            resp_valid   <= 1'b1;
            state        <= S_IDLE;
          end else if (to_cnt == TO_LAST) begin
            resp_data    <= 8'h00;
            resp_timeout <= 1'b1;
            resp_valid   <= 1'b1;
            state        <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_host.sv
// Directed bench for uart_alu_host: the bench plays both uart_tx and uart_rx,
// stepping on falling edges and comparing against hand-computed values.
module tb_uart_alu_host;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [5:0] cmd_op;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done_tick;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_timeout;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_alu_host #(.OP_W(6), .TIMEOUT_CYC(50), .TO_BITS(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_op       (cmd_op),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_timeout (resp_timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // tx_start must never be high on two consecutive cycles.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) check("tx_start_gap", {31'd0, prev}, 32'd0);
      prev = tx_start;
    end
  end

  // Present a command for one cycle; ends in the SEND cycle.
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    check("accept_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("send_busy", {31'd0, busy}, 32'd1);
    check("send_no_start", {31'd0, tx_start}, 32'd0);
  endtask

  // Acts as uart_tx for three frames; ends with the host in WAIT_RX, counter at 0.
  task automatic tx_bytes(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                          input bit stray);
    logic [7:0] exp_b [3];
    exp_b[0] = e0;
    exp_b[1] = e1;
    exp_b[2] = e2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("tx_start_%0d", i), {31'd0, tx_start}, 32'd1);
      check($sformatf("tx_data_%0d", i), {24'd0, tx_data}, {24'd0, exp_b[i]});
      @(negedge clk);
      check($sformatf("tx_pulse_%0d", i), {31'd0, tx_start}, 32'd0);
      check($sformatf("tx_hold_%0d", i), {24'd0, tx_data}, {24'd0, exp_b[i]});
      check($sformatf("busy_ready_%0d", i), {31'd0, cmd_ready}, 32'd0);
      if (stray && i == 0) begin
        rx_done_tick = 1'b1;
        rx_data      = 8'hAA;
      end
      @(negedge clk);
      rx_done_tick = 1'b0;
      if (stray && i == 0) check("stray_no_resp", {31'd0, resp_valid}, 32'd0);
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
    end
  endtask

  // Acts as uart_rx after a delay; ends in the cycle resp_valid is high.
  task automatic reply(input int delay, input logic [7:0] data);
    repeat (delay) begin
      @(negedge clk);
      check("rx_wait_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    rx_done_tick = 1'b1;
    rx_data      = data;
    @(negedge clk);
    rx_done_tick = 1'b0;
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    check("resp_data", {24'd0, resp_data}, {24'd0, data});
    check("resp_timeout", {31'd0, resp_timeout}, 32'd0);
    check("resp_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic post_idle(input logic [7:0] data);
    @(negedge clk);
    check("post_valid_low", {31'd0, resp_valid}, 32'd0);
    check("post_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_data_hold", {24'd0, resp_data}, {24'd0, data});
  endtask

  initial begin
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_a        = 8'h00;
    cmd_b        = 8'h00;
    cmd_op       = 6'h00;
    tx_done_tick = 1'b0;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", {24'd0, resp_data}, 32'd0);
    check("rst_resp_timeout", {31'd0, resp_timeout}, 32'd0);

    // Basic exchange
    accept(8'h05, 8'h03, 6'h20);
    tx_bytes(8'h05, 8'h03, 8'h20, 1'b0);
    reply(4, 8'h08);
    post_idle(8'h08);

    // Timeout: response exactly 50 cycles after entering WAIT_RX
    accept(8'hA1, 8'hB2, 6'h3F);
    tx_bytes(8'hA1, 8'hB2, 8'h3F, 1'b0);
    repeat (49) begin
      @(negedge clk);
      check("to_early", {31'd0, resp_valid}, 32'd0);
    end
    @(negedge clk);
    check("to_valid", {31'd0, resp_valid}, 32'd1);
    check("to_flag", {31'd0, resp_timeout}, 32'd1);
    check("to_data", {24'd0, resp_data}, 32'd0);
    @(negedge clk);
    check("to_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("to_valid_low", {31'd0, resp_valid}, 32'd0);
    check("to_flag_hold", {31'd0, resp_timeout}, 32'd1);

    // Stray rx byte during WAIT_TX, then the real reply
    accept(8'h12, 8'h34, 6'h15);
    tx_bytes(8'h12, 8'h34, 8'h15, 1'b1);
    reply(3, 8'h11);
    post_idle(8'h11);

    // Spurious tx_done_tick in IDLE
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    repeat (3) begin
      check("idle_done_no_start", {31'd0, tx_start}, 32'd0);
      check("idle_done_no_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end

    // Race: rx byte on the cycle the counter hits 49
    accept(8'h22, 8'h33, 6'h01);
    tx_bytes(8'h22, 8'h33, 8'h01, 1'b0);
    repeat (49) begin
      @(negedge clk);
      check("race_early", {31'd0, resp_valid}, 32'd0);
    end
    rx_done_tick = 1'b1;
    rx_data      = 8'h7F;
    @(negedge clk);
    rx_done_tick = 1'b0;
    check("race_valid", {31'd0, resp_valid}, 32'd1);
    check("race_data", {24'd0, resp_data}, 32'h7F);
    check("race_timeout", {31'd0, resp_timeout}, 32'd0);
    post_idle(8'h7F);

    // Reset during WAIT_TX of byte B
    accept(8'h5A, 8'hC3, 6'h2A);
    @(negedge clk);
    check("rm_start_a", {31'd0, tx_start}, 32'd1);
    check("rm_data_a", {24'd0, tx_data}, 32'h5A);
    @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    @(negedge clk);
    check("rm_start_b", {31'd0, tx_start}, 32'd1);
    check("rm_data_b", {24'd0, tx_data}, 32'hC3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rm_ready", {31'd0, cmd_ready}, 32'd1);
    check("rm_busy", {31'd0, busy}, 32'd0);
    check("rm_tx_start", {31'd0, tx_start}, 32'd0);
    check("rm_tx_data", {24'd0, tx_data}, 32'd0);
    check("rm_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rm_resp_data", {24'd0, resp_data}, 32'd0);
    check("rm_resp_timeout", {31'd0, resp_timeout}, 32'd0);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    check("rm_late_no_start", {31'd0, tx_start}, 32'd0);
    check("rm_late_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("rm_late_no_start2", {31'd0, tx_start}, 32'd0);
    accept(8'h66, 8'h77, 6'h0C);
    tx_bytes(8'h66, 8'h77, 8'h0C, 1'b0);
    reply(2, 8'hE5);
    post_idle(8'hE5);

    // Back-to-back with cmd_valid held and cmd_a changed during SEND
    cmd_valid = 1'b1;
    cmd_a     = 8'h31;
    cmd_b     = 8'h32;
    cmd_op    = 6'h03;
    @(negedge clk);
    cmd_a = 8'h99;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    tx_bytes(8'h31, 8'h32, 8'h03, 1'b0);
    reply(3, 8'h44);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_second_accepted", {31'd0, busy}, 32'd1);
    check("b2b_valid_low", {31'd0, resp_valid}, 32'd0);
    check("b2b_no_start_yet", {31'd0, tx_start}, 32'd0);
    tx_bytes(8'h99, 8'h32, 8'h03, 1'b0);
    reply(2, 8'h55);
    post_idle(8'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
